// File: rtl/ym6045c_busreq_responder.sv
`default_nettype none
// ============================================================================
// Module   : ym6045c_busreq_responder
// Purpose  : CPU-side end of the BR_n / BG_n / BGACK_n bus-arbitration
//            handshake. Hands the bus to an external master only once the
//            local master's bus cycle has completed. Also serves as a
//            silicon-side model when verifying the arbiter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SYNC_STAGES  synchronizer depth on br_n and bgack_n (>= 1)
//   RECOVER_CYC  idle cycles after release before local ownership (0 = none)
//   GRANT_TMO    cycles bg_n may stay low without bgack_n (timeout build only)
// Ports
//   clk       in   rising-edge clock
//   res       in   synchronous reset, active-high
//   br_n      in   bus request from arbiter, asynchronous, active-low
//   bgack_n   in   grant acknowledge from external master, async, active-low
//   loc_req   in   local master wants a bus cycle (advisory only)
//   loc_busy  in   local bus cycle in progress
//   loc_go    out  local master may start a cycle this clock
//   bg_n      out  bus grant to arbiter, active-low, registered
//   bus_oe    out  local master may drive the bus, registered
//   state     out  FSM state for debug (OWN=0 PEND=1 GRANT=2 REL=3 RECOV=4)
//   tmo       out  one-cycle pulse on grant timeout (tied 0 without macro)
// Configuration
//   YM6045C_BUSREQ_RESP_TMO_EN : when defined, builds the grant timeout
//   counter and the re-request lockout.
// ============================================================================
module ym6045c_busreq_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int RECOVER_CYC = 1,
  parameter int GRANT_TMO   = 64
) (
  input  logic       clk,
  input  logic       res,
  input  logic       br_n,
  input  logic       bgack_n,
  input  logic       loc_req,
  input  logic       loc_busy,
  output logic       loc_go,
  output logic       bg_n,
  output logic       bus_oe,
  output logic [2:0] state,
  output logic       tmo
);

  typedef enum logic [2:0] {
    S_OWN   = 3'd0,
    S_PEND  = 3'd1,
    S_GRANT = 3'd2,
    S_REL   = 3'd3,
    S_RECOV = 3'd4
  } state_t;

  // Recovery counter: width covers 0..RECOVER_CYC, at least one bit so the
  // RECOVER_CYC=0 build still elaborates (RECOV is then unreachable).
  localparam int c_RCW = (RECOVER_CYC > 0) ? $clog2(RECOVER_CYC + 1) : 1;
  localparam logic [c_RCW-1:0] c_RLAST = c_RCW'((RECOVER_CYC > 0) ? RECOVER_CYC - 1 : 0);

`ifdef YM6045C_BUSREQ_RESP_TMO_EN
  localparam int c_TW = $clog2(GRANT_TMO + 1);
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(GRANT_TMO - 1);
`endif

  // --------------------------------------------------------------------------
  // Input synchronizers (reset to the inactive level)
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_br_sync;
  logic [SYNC_STAGES-1:0] r_bgack_sync;
  logic                   w_br_s;
  logic                   w_bgack_s;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_ff @(posedge clk) begin
        if (res) begin
          r_br_sync    <= 1'b1;
          r_bgack_sync <= 1'b1;
        end else begin
          r_br_sync    <= br_n;
          r_bgack_sync <= bgack_n;
        end
      end
    end else begin : g_sync_chain
      always_ff @(posedge clk) begin
        if (res) begin
          r_br_sync    <= '1;
          r_bgack_sync <= '1;
        end else begin
          r_br_sync    <= {r_br_sync[SYNC_STAGES-2:0], br_n};
          r_bgack_sync <= {r_bgack_sync[SYNC_STAGES-2:0], bgack_n};
        end
      end
    end
  endgenerate

  assign w_br_s    = r_br_sync[SYNC_STAGES-1];
  assign w_bgack_s = r_bgack_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // State and counters
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_next;
  logic             r_bg_n;
  logic             r_bus_oe;
  logic [c_RCW-1:0] r_rcnt;
  logic             r_held;     // request seen during RECOV, granted on exit
  logic             w_rec_exit;
  logic             w_req;      // effective (non-locked-out) bus request
  logic             w_lock;
  logic             w_tmo_hit;
  logic             w_timeout;

`ifdef YM6045C_BUSREQ_RESP_TMO_EN
  logic [c_TW-1:0]  r_tcnt;
  logic             r_tmo;
  logic             r_lock;     // set by a timeout, cleared once br_s returns high
  assign w_lock    = r_lock;
  assign w_tmo_hit = (r_tcnt == c_TLAST);
  assign tmo       = r_tmo;
`else
  assign w_lock    = 1'b0;
  assign w_tmo_hit = 1'b0;
  assign tmo       = 1'b0;
`endif

  assign w_req      = ~w_br_s & ~w_lock;
  assign w_rec_exit = (r_rcnt == c_RLAST);

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_OWN: begin
        // A running local cycle is never aborted: busy defers the grant.
        if (w_req & ~loc_busy)
          w_next = S_GRANT;
        else if (w_req & loc_busy)
          w_next = S_PEND;
        else if (w_br_s & ~w_bgack_s & ~loc_busy)
          w_next = S_REL;           // external master took the bus unasked
      end
      S_PEND: begin
        if (~w_req)
          w_next = S_OWN;
        else if (~loc_busy)
          w_next = S_GRANT;
      end
      S_GRANT: begin
        if (~w_bgack_s)
          w_next = S_REL;
        else if (w_br_s)
          w_next = S_OWN;
        else if (w_tmo_hit) begin
          w_next    = S_OWN;
          w_timeout = 1'b1;
        end
      end
      S_REL: begin
        if (w_bgack_s) begin
          if (~w_br_s)
            w_next = S_GRANT;       // chained request, no recovery gap
          else if (RECOVER_CYC == 0)
            w_next = S_OWN;
          else
            w_next = S_RECOV;
        end
      end
      S_RECOV: begin
        if (w_rec_exit)
          w_next = (r_held | ~w_br_s) ? S_GRANT : S_OWN;
      end
      default: w_next = S_OWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state  <= S_OWN;
      r_bg_n   <= 1'b1;
      r_bus_oe <= 1'b0;
      r_rcnt   <= '0;
      r_held   <= 1'b0;
`ifdef YM6045C_BUSREQ_RESP_TMO_EN
      r_tcnt   <= '0;
      r_tmo    <= 1'b0;
      r_lock   <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      // Outputs follow the state being entered so they change on the same edge.
      r_bg_n   <= (w_next != S_GRANT);
      r_bus_oe <= (w_next == S_OWN) || (w_next == S_PEND) || (w_next == S_GRANT);

      if (r_state == S_RECOV) begin
        if (r_rcnt != c_RLAST)
          r_rcnt <= r_rcnt + 1'b1;
        r_held <= r_held | ~w_br_s;
      end else begin
        r_rcnt <= '0;
        r_held <= 1'b0;
      end

`ifdef YM6045C_BUSREQ_RESP_TMO_EN
      r_tmo <= w_timeout;
      if (r_state == S_GRANT) begin
        if (w_bgack_s && (r_tcnt != c_TLAST))
          r_tcnt <= r_tcnt + 1'b1;
      end else begin
        r_tcnt <= '0;
      end
      if (w_timeout)
        r_lock <= 1'b1;
      else if (w_br_s)
        r_lock <= 1'b0;
`endif
    end
  end

  // Bus request beats a same-cycle local request; held low during reset.
  assign loc_go = (r_state == S_OWN) & w_br_s & w_bgack_s & ~res;
  assign bg_n   = r_bg_n;
  assign bus_oe = r_bus_oe;
  assign state  = r_state;

  // loc_req is advisory and does not steer the FSM; GRANT_TMO only matters
  // in the timeout build.
  logic w_unused;
  assign w_unused = loc_req | (GRANT_TMO < 1);

endmodule
`default_nettype wire

// File: tb/tb_ym6045c_busreq_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ym6045c_busreq_responder
// Purpose  : Directed self-checking bench for ym6045c_busreq_responder
//            (SYNC_STAGES=2, RECOVER_CYC=1, GRANT_TMO=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ym6045c_busreq_responder;

  logic       clk = 1'b0;
  logic       res;
  logic       br_n;
  logic       bgack_n;
  logic       loc_req;
  logic       loc_busy;
  logic       loc_go;
  logic       bg_n;
  logic       bus_oe;
  logic [2:0] state;
  logic       tmo;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] OWN = 3'd0, PEND = 3'd1, GRANT = 3'd2, REL = 3'd3, RECOV = 3'd4;

  always #5 clk = ~clk;

  ym6045c_busreq_responder #(
    .SYNC_STAGES(2),
    .RECOVER_CYC(1),
    .GRANT_TMO  (8)
  ) dut (
    .clk     (clk),
    .res     (res),
    .br_n    (br_n),
    .bgack_n (bgack_n),
    .loc_req (loc_req),
    .loc_busy(loc_busy),
    .loc_go  (loc_go),
    .bg_n    (bg_n),
    .bus_oe  (bus_oe),
    .state   (state),
    .tmo     (tmo)
  );

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    res = 1'b1; br_n = 1'b1; bgack_n = 1'b1; loc_req = 1'b0; loc_busy = 1'b0;

    // Reset values
    step(2);
    chk("rst_bg_n",   bg_n,   1);
    chk("rst_bus_oe", bus_oe, 0);
    chk("rst_loc_go", loc_go, 0);
    chk("rst_tmo",    tmo,    0);
    chk("rst_state",  state,  OWN);

    res = 1'b0; loc_req = 1'b1;
    step(1);
    chk("own_bus_oe", bus_oe, 1);
    chk("own_loc_go", loc_go, 1);
    chk("own_bg_n",   bg_n,   1);

    // 1: request with idle local master, two-stage sync latency
    br_n = 1'b0;
    step(1);
    chk("t1_e1_bg_n",   bg_n,   1);
    chk("t1_e1_loc_go", loc_go, 1);
    step(1);
    chk("t1_e2_loc_go", loc_go, 0);
    chk("t1_e2_bg_n",   bg_n,   1);
    step(1);
    chk("t1_bg_n",   bg_n,   0);
    chk("t1_state",  state,  GRANT);
    chk("t1_bus_oe", bus_oe, 1);

    // 4: request withdrawn before acknowledge
    br_n = 1'b1;
    step(2);
    chk("t4_still_bg_n", bg_n, 0);
    step(1);
    chk("t4_state",  state,  OWN);
    chk("t4_bg_n",   bg_n,   1);
    chk("t4_bus_oe", bus_oe, 1);
    chk("t4_loc_go", loc_go, 1);

    // 2: request while local cycle busy for 5 cycles
    br_n = 1'b0; loc_busy = 1'b1;
    step(3);
    chk("t2_pend_state", state, PEND);
    chk("t2_pend_bg_n",  bg_n,  1);
    step(2);
    chk("t2_pend2_state", state, PEND);
    chk("t2_pend2_bg_n",  bg_n,  1);
    chk("t2_pend_bus_oe", bus_oe, 1);
    loc_busy = 1'b0;
    step(1);
    chk("t2_bg_n",  bg_n,  0);
    chk("t2_state", state, GRANT);

    // 3: acknowledge, release, one recovery cycle
    bgack_n = 1'b0;
    step(2);
    chk("t3_pre_bg_n", bg_n, 0);
    step(1);
    chk("t3_rel_state",  state,  REL);
    chk("t3_rel_bg_n",   bg_n,   1);
    chk("t3_rel_bus_oe", bus_oe, 0);
    bgack_n = 1'b1; br_n = 1'b1;
    step(3);
    chk("t3_recov_state",  state,  RECOV);
    chk("t3_recov_bus_oe", bus_oe, 0);
    chk("t3_recov_loc_go", loc_go, 0);
    step(1);
    chk("t3_own_state",  state,  OWN);
    chk("t3_own_bus_oe", bus_oe, 1);
    chk("t3_own_loc_go", loc_go, 1);

    // 5: chained request straight from REL back to GRANT
    br_n = 1'b0;
    step(3);
    chk("t5_grant_bg_n", bg_n, 0);
    bgack_n = 1'b0;
    step(3);
    chk("t5_rel_state", state, REL);
    bgack_n = 1'b1;
    step(2);
    chk("t5_rel_hold_state", state, REL);
    step(1);
    chk("t5_chain_state", state, GRANT);
    chk("t5_chain_bg_n",  bg_n,  0);

    // 5b: reset while in REL
    bgack_n = 1'b0;
    step(3);
    chk("t5b_rel_state", state, REL);
    res = 1'b1;
    step(1);
    chk("t5b_rst_bg_n",   bg_n,   1);
    chk("t5b_rst_bus_oe", bus_oe, 0);
    chk("t5b_rst_state",  state,  OWN);
    chk("t5b_rst_loc_go", loc_go, 0);
    res = 1'b0; br_n = 1'b1; bgack_n = 1'b1;
    step(2);
    chk("t5b_own_bus_oe", bus_oe, 1);

    // Unsolicited takeover, then a request arriving during RECOV
    bgack_n = 1'b0;
    step(3);
    chk("tk_state",  state,  REL);
    chk("tk_bus_oe", bus_oe, 0);
    chk("tk_bg_n",   bg_n,   1);
    bgack_n = 1'b1;
    step(1);
    br_n = 1'b0;
    step(2);
    chk("tk_recov_state", state, RECOV);
    step(1);
    chk("tk_exit_state", state, GRANT);
    chk("tk_exit_bg_n",  bg_n,  0);
    br_n = 1'b1;
    step(3);
    chk("tk_back_state", state, OWN);

    // 6: grant without acknowledge
    br_n = 1'b0;
    step(3);
    chk("t6_bg_n", bg_n, 0);
`ifdef YM6045C_BUSREQ_RESP_TMO_EN
    step(7);
    chk("t6_pre_bg_n", bg_n, 0);
    chk("t6_pre_tmo",  tmo,  0);
    step(1);
    chk("t6_tmo",       tmo,   1);
    chk("t6_tmo_bg_n",  bg_n,  1);
    chk("t6_tmo_state", state, OWN);
    step(1);
    chk("t6_tmo_pulse", tmo,  0);
    step(5);
    chk("t6_lock_bg_n", bg_n, 1);
    br_n = 1'b1;
    step(3);
    br_n = 1'b0;
    step(3);
    chk("t6_regrant_bg_n", bg_n, 0);
`else
    step(20);
    chk("t6_wait_bg_n",  bg_n,  0);
    chk("t6_wait_state", state, GRANT);
    chk("t6_wait_tmo",   tmo,   0);
`endif
    br_n = 1'b1;
    step(3);
    chk("end_state", state, OWN);
    chk("end_tmo",   tmo,   0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
